// File: rtl/opendram_cmd_pkg.sv
// Shared command encodings, default field widths and command classification helpers
// for the OpenDRAM command path.
package opendram_cmd_pkg;

    localparam int DEF_CMD_TYPE_WIDTH = 3;
    localparam int DEF_CH_WIDTH       = 1;
    localparam int DEF_RNK_WIDTH      = 1;
    localparam int DEF_BG_WIDTH       = 2;
    localparam int DEF_BNK_WIDTH      = 3;
    localparam int DEF_ROW_WIDTH      = 3;
    localparam int DEF_COL_WIDTH      = 6;
    localparam int DEF_DATA_PTR_WIDTH = 4;
    localparam int DEF_NUM_BNK_TOT    = 16;
    localparam int DEF_TIMER_WIDTH    = 4;

    localparam logic [7:0] CMD_NOP = 8'd0;
    localparam logic [7:0] CMD_PRE = 8'd1;
    localparam logic [7:0] CMD_ACT = 8'd2;
    localparam logic [7:0] CMD_RD  = 8'd3;
    localparam logic [7:0] CMD_WR  = 8'd4;

    typedef enum logic [1:0] {
        CK_NONE = 2'd0,
        CK_PRE  = 2'd1,
        CK_ACT  = 2'd2,
        CK_CAS  = 2'd3
    } cmd_kind_e;

    function automatic logic is_cas(input logic [7:0] cmd);
        return (cmd == CMD_RD) || (cmd == CMD_WR);
    endfunction

    // NOP and every undefined encoding collapse to CK_NONE, which is never arbitrated.
    function automatic cmd_kind_e cmd_kind(input logic [7:0] cmd);
        cmd_kind_e k;
        k = CK_NONE;
        if (cmd == CMD_PRE)
            k = CK_PRE;
        else if (cmd == CMD_ACT)
            k = CK_ACT;
        else if (is_cas(cmd))
            k = CK_CAS;
        return k;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping from N-1 back to 0. The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int N = 16,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx,
    output logic          o_any_grant
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, i_ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N))
                sum = sum - (IW+1)'(N);
            idx = sum[IW-1:0];
            if (!o_any_grant && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                o_grant_idx  = idx;
                o_any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/command_issue_arbiter.sv
// Per-bank head-of-queue command arbiter with tRCD/tRP/tCCD spacing and a registered
// valid/ready issue stage. Define ISSUE_STATS_EN to add issue/stall counters.
module command_issue_arbiter
    import opendram_cmd_pkg::*;
#(
    parameter int CMD_TYPE_WIDTH = DEF_CMD_TYPE_WIDTH,
    parameter int CH_WIDTH       = DEF_CH_WIDTH,
    parameter int RNK_WIDTH      = DEF_RNK_WIDTH,
    parameter int BG_WIDTH       = DEF_BG_WIDTH,
    parameter int BNK_WIDTH      = DEF_BNK_WIDTH,
    parameter int ROW_WIDTH      = DEF_ROW_WIDTH,
    parameter int COL_WIDTH      = DEF_COL_WIDTH,
    parameter int DATA_PTR_WIDTH = DEF_DATA_PTR_WIDTH,
    parameter int NUM_BNK_TOT    = DEF_NUM_BNK_TOT,
    parameter int T_RCD          = 4,
    parameter int T_RP           = 4,
    parameter int T_CCD          = 2,
    parameter int TIMER_WIDTH    = DEF_TIMER_WIDTH,
    localparam int IDX_W = (NUM_BNK_TOT > 1) ? $clog2(NUM_BNK_TOT) : 1
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst,
    input  logic [NUM_BNK_TOT-1:0]                        i_valid,
    input  logic [NUM_BNK_TOT-1:0][CMD_TYPE_WIDTH-1:0]    i_cmd,
    input  logic [NUM_BNK_TOT-1:0][CH_WIDTH-1:0]          i_channel,
    input  logic [NUM_BNK_TOT-1:0][RNK_WIDTH-1:0]         i_rank,
    input  logic [NUM_BNK_TOT-1:0][BG_WIDTH-1:0]          i_bgroup,
    input  logic [NUM_BNK_TOT-1:0][BNK_WIDTH-1:0]         i_bank,
    input  logic [NUM_BNK_TOT-1:0][ROW_WIDTH-1:0]         i_row,
    input  logic [NUM_BNK_TOT-1:0][COL_WIDTH-1:0]         i_column,
    input  logic [NUM_BNK_TOT-1:0][DATA_PTR_WIDTH-1:0]    i_data_ptr,
    output logic [NUM_BNK_TOT-1:0]                        o_dequeue,
    output logic                                          o_cmd_valid,
    input  logic                                          i_cmd_ready,
    output logic [CMD_TYPE_WIDTH-1:0]                     o_cmd,
    output logic [CH_WIDTH-1:0]                           o_channel,
    output logic [RNK_WIDTH-1:0]                          o_rank,
    output logic [BG_WIDTH-1:0]                           o_bgroup,
    output logic [BNK_WIDTH-1:0]                          o_bank,
    output logic [ROW_WIDTH-1:0]                          o_row,
    output logic [COL_WIDTH-1:0]                          o_column,
    output logic [DATA_PTR_WIDTH-1:0]                     o_data_ptr,
    output logic [IDX_W-1:0]                              o_grant_idx
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0]                                   o_issue_count,
    output logic [31:0]                                   o_stall_count
`endif
);

    logic [NUM_BNK_TOT-1:0][TIMER_WIDTH-1:0] bank_timer_q, bank_timer_d;
    logic [TIMER_WIDTH-1:0]                  cas_timer_q, cas_timer_d;
    logic [IDX_W-1:0]                        rr_ptr_q, rr_ptr_d;

    logic                      cmd_valid_q, cmd_valid_d;
    logic [CMD_TYPE_WIDTH-1:0] cmd_q, cmd_d;
    logic [CH_WIDTH-1:0]       channel_q, channel_d;
    logic [RNK_WIDTH-1:0]      rank_q, rank_d;
    logic [BG_WIDTH-1:0]       bgroup_q, bgroup_d;
    logic [BNK_WIDTH-1:0]      bank_q, bank_d;
    logic [ROW_WIDTH-1:0]      row_q, row_d;
    logic [COL_WIDTH-1:0]      column_q, column_d;
    logic [DATA_PTR_WIDTH-1:0] data_ptr_q, data_ptr_d;
    logic [IDX_W-1:0]          grant_idx_q, grant_idx_d;

    logic                   stage_free;
    logic [NUM_BNK_TOT-1:0] req;
    logic [NUM_BNK_TOT-1:0] grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   any_grant;
    cmd_kind_e              grant_kind;

    assign stage_free = !cmd_valid_q || i_cmd_ready;

    // Requests are masked here so the arbiter never grants into a stalled stage or during reset.
    always_comb begin
        req = '0;
        for (int b = 0; b < NUM_BNK_TOT; b++) begin
            if (!i_rst && stage_free && i_valid[b] && (bank_timer_q[b] == '0)) begin
                case (cmd_kind(8'(i_cmd[b])))
                    CK_PRE, CK_ACT: req[b] = 1'b1;
                    CK_CAS:         req[b] = (cas_timer_q == '0);
                    default:        req[b] = 1'b0;
                endcase
            end
        end
    end

    rr_arbiter #(
        .N (NUM_BNK_TOT)
    ) u_rr_arbiter (
        .i_req       (req),
        .i_ptr       (rr_ptr_q),
        .o_grant     (grant),
        .o_grant_idx (grant_idx),
        .o_any_grant (any_grant)
    );

    assign o_dequeue  = grant;
    assign grant_kind = cmd_kind(8'(i_cmd[grant_idx]));

    always_comb begin
        for (int b = 0; b < NUM_BNK_TOT; b++)
            bank_timer_d[b] = (bank_timer_q[b] != '0) ? bank_timer_q[b] - 1'b1 : '0;
        cas_timer_d = (cas_timer_q != '0) ? cas_timer_q - 1'b1 : '0;
        if (any_grant) begin
            case (grant_kind)
                CK_PRE:  bank_timer_d[grant_idx] = TIMER_WIDTH'(T_RP - 1);
                CK_ACT:  bank_timer_d[grant_idx] = TIMER_WIDTH'(T_RCD - 1);
                CK_CAS:  cas_timer_d             = TIMER_WIDTH'(T_CCD - 1);
                default: ;
            endcase
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_grant)
            rr_ptr_d = (32'(grant_idx) == NUM_BNK_TOT - 1) ? '0 : grant_idx + 1'b1;
    end

    // Fields only move on a grant; an idle free stage just drops valid.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_d       = cmd_q;
        channel_d   = channel_q;
        rank_d      = rank_q;
        bgroup_d    = bgroup_q;
        bank_d      = bank_q;
        row_d       = row_q;
        column_d    = column_q;
        data_ptr_d  = data_ptr_q;
        grant_idx_d = grant_idx_q;
        if (any_grant) begin
            cmd_valid_d = 1'b1;
            cmd_d       = i_cmd[grant_idx];
            channel_d   = i_channel[grant_idx];
            rank_d      = i_rank[grant_idx];
            bgroup_d    = i_bgroup[grant_idx];
            bank_d      = i_bank[grant_idx];
            row_d       = i_row[grant_idx];
            column_d    = i_column[grant_idx];
            data_ptr_d  = i_data_ptr[grant_idx];
            grant_idx_d = grant_idx;
        end else if (stage_free) begin
            cmd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bank_timer_q <= '0;
            cas_timer_q  <= '0;
            rr_ptr_q     <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_q        <= '0;
            channel_q    <= '0;
            rank_q       <= '0;
            bgroup_q     <= '0;
            bank_q       <= '0;
            row_q        <= '0;
            column_q     <= '0;
            data_ptr_q   <= '0;
            grant_idx_q  <= '0;
        end else begin
            bank_timer_q <= bank_timer_d;
            cas_timer_q  <= cas_timer_d;
            rr_ptr_q     <= rr_ptr_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_q        <= cmd_d;
            channel_q    <= channel_d;
            rank_q       <= rank_d;
            bgroup_q     <= bgroup_d;
            bank_q       <= bank_d;
            row_q        <= row_d;
            column_q     <= column_d;
            data_ptr_q   <= data_ptr_d;
            grant_idx_q  <= grant_idx_d;
        end
    end

    assign o_cmd_valid = cmd_valid_q;
    assign o_cmd       = cmd_q;
    assign o_channel   = channel_q;
    assign o_rank      = rank_q;
    assign o_bgroup    = bgroup_q;
    assign o_bank      = bank_q;
    assign o_row       = row_q;
    assign o_column    = column_q;
    assign o_data_ptr  = data_ptr_q;
    assign o_grant_idx = grant_idx_q;

`ifdef ISSUE_STATS_EN
    logic [31:0] issue_count_q, issue_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    always_comb begin
        issue_count_d = issue_count_q;
        stall_count_d = stall_count_q;
        if (any_grant)
            issue_count_d = issue_count_q + 32'd1;
        else if (|i_valid)
            stall_count_d = stall_count_q + 32'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            issue_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            issue_count_q <= issue_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign o_issue_count = issue_count_q;
    assign o_stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_command_issue_arbiter.sv
// Scoreboard bench for command_issue_arbiter: per-bank head queues feed the DUT,
// expected issues are queued at stimulus time and checked by a negedge monitor.
module tb_command_issue_arbiter;
    import opendram_cmd_pkg::*;

    localparam int NB = 16;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic [NB-1:0]        i_valid = '0;
    logic [NB-1:0][2:0]   i_cmd = '0;
    logic [NB-1:0][0:0]   i_channel = '0;
    logic [NB-1:0][0:0]   i_rank = '0;
    logic [NB-1:0][1:0]   i_bgroup = '0;
    logic [NB-1:0][2:0]   i_bank = '0;
    logic [NB-1:0][2:0]   i_row = '0;
    logic [NB-1:0][5:0]   i_column = '0;
    logic [NB-1:0][3:0]   i_data_ptr = '0;
    logic [NB-1:0]        o_dequeue;
    logic                 o_cmd_valid;
    logic                 i_cmd_ready = 1'b1;
    logic [2:0]           o_cmd;
    logic [0:0]           o_channel;
    logic [0:0]           o_rank;
    logic [1:0]           o_bgroup;
    logic [2:0]           o_bank;
    logic [2:0]           o_row;
    logic [5:0]           o_column;
    logic [3:0]           o_data_ptr;
    logic [3:0]           o_grant_idx;
`ifdef ISSUE_STATS_EN
    logic [31:0]          o_issue_count;
    logic [31:0]          o_stall_count;
`endif

    command_issue_arbiter dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_cmd       (i_cmd),
        .i_channel   (i_channel),
        .i_rank      (i_rank),
        .i_bgroup    (i_bgroup),
        .i_bank      (i_bank),
        .i_row       (i_row),
        .i_column    (i_column),
        .i_data_ptr  (i_data_ptr),
        .o_dequeue   (o_dequeue),
        .o_cmd_valid (o_cmd_valid),
        .i_cmd_ready (i_cmd_ready),
        .o_cmd       (o_cmd),
        .o_channel   (o_channel),
        .o_rank      (o_rank),
        .o_bgroup    (o_bgroup),
        .o_bank      (o_bank),
        .o_row       (o_row),
        .o_column    (o_column),
        .o_data_ptr  (o_data_ptr),
        .o_grant_idx (o_grant_idx)
`ifdef ISSUE_STATS_EN
        ,
        .o_issue_count (o_issue_count),
        .o_stall_count (o_stall_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0] cmd;
        logic [5:0] tag;
    } ent_t;

    typedef struct {
        int         bank;
        logic [2:0] cmd;
        logic [5:0] tag;
        int         gap;
    } exp_t;

    localparam logic [2:0] C_PRE = 3'd1;
    localparam logic [2:0] C_ACT = 3'd2;
    localparam logic [2:0] C_RD  = 3'd3;
    localparam logic [2:0] C_WR  = 3'd4;

    ent_t          bq[NB][$];
    exp_t          exp_q[$];
    int            gq[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            prev_grant = -1;
    logic [NB-1:0] deq_last = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge i_clk) cyc++;

    // Monitor: records grant cycles and checks every accepted issue against the scoreboard.
    exp_t mon_e;
    int   mon_g;
    always @(negedge i_clk) begin
        deq_last = o_dequeue;
        if (!i_rst) begin
            if (|o_dequeue) begin
                check("dequeue_onehot", 64'($onehot(o_dequeue)), 64'd1);
                gq.push_back(cyc);
            end
            if (o_cmd_valid && i_cmd_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_issue_idx", 64'(o_grant_idx), 64'hFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_g = (gq.size() > 0) ? gq.pop_front() : -1;
                    check("issue_idx", 64'(o_grant_idx), 64'(mon_e.bank));
                    check("issue_cmd", 64'(o_cmd), 64'(mon_e.cmd));
                    check("issue_fields",
                          64'({o_channel, o_rank, o_bgroup, o_bank, o_row, o_column, o_data_ptr}),
                          64'({mon_e.bank[3], mon_e.tag[0], mon_e.bank[1:0], mon_e.bank[2:0],
                               mon_e.tag[2:0], mon_e.tag, mon_e.tag[3:0]}));
                    if (mon_e.gap >= 0)
                        check("issue_gap", 64'(mon_g - prev_grant), 64'(mon_e.gap));
                    prev_grant = mon_g;
                end
            end
        end
    end

    task automatic drive_heads();
        for (int b = 0; b < NB; b++) begin
            if (bq[b].size() > 0) begin
                i_valid[b]    = 1'b1;
                i_cmd[b]      = bq[b][0].cmd;
                i_channel[b]  = 1'(b >> 3);
                i_rank[b]     = bq[b][0].tag[0];
                i_bgroup[b]   = 2'(b);
                i_bank[b]     = 3'(b);
                i_row[b]      = bq[b][0].tag[2:0];
                i_column[b]   = bq[b][0].tag;
                i_data_ptr[b] = bq[b][0].tag[3:0];
            end else begin
                i_valid[b]    = 1'b0;
                i_cmd[b]      = '0;
                i_channel[b]  = '0;
                i_rank[b]     = '0;
                i_bgroup[b]   = '0;
                i_bank[b]     = '0;
                i_row[b]      = '0;
                i_column[b]   = '0;
                i_data_ptr[b] = '0;
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        for (int b = 0; b < NB; b++)
            if (deq_last[b] && bq[b].size() > 0)
                void'(bq[b].pop_front());
        drive_heads();
    endtask

    task automatic push_cmd(input int b, input logic [2:0] c, input logic [5:0] tag, input int gap);
        bq[b].push_back('{cmd: c, tag: tag});
        exp_q.push_back('{bank: b, cmd: c, tag: tag, gap: gap});
    endtask

    task automatic flush_bench();
        for (int b = 0; b < NB; b++) bq[b].delete();
        exp_q.delete();
        gq.delete();
        prev_grant = -1;
        drive_heads();
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        i_cmd_ready = 1'b1;
        flush_bench();
        repeat (2) tick();
        i_rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and single ACT then RD on bank 3.
        do_reset();
        @(negedge i_clk);
        check("rst_valid", 64'(o_cmd_valid), 64'd0);
        check("rst_dequeue", 64'(o_dequeue), 64'd0);
        check("rst_fields", 64'({o_cmd, o_grant_idx, o_column, o_data_ptr}), 64'd0);
`ifdef ISSUE_STATS_EN
        check("rst_stats", 64'({o_issue_count, o_stall_count}), 64'd0);
`endif
        tick();
        push_cmd(3, C_ACT, 6'd1, -1);
        push_cmd(3, C_RD,  6'd2, 4);
        drive_heads();
        @(negedge i_clk);
        check("t1_dequeue", 64'(o_dequeue), 64'h0008);
        wait_drain("t1_drain", 20);
`ifdef ISSUE_STATS_EN
        check("t1_issue_count", 64'(o_issue_count), 64'd2);
        check("t1_stall_count", 64'(o_stall_count), 64'd3);
`endif

        // Round robin across 0/5/15, then wrap back to the start.
        do_reset();
        tick();
        push_cmd(0,  C_ACT, 6'd3, -1);
        push_cmd(5,  C_ACT, 6'd4, 1);
        push_cmd(15, C_ACT, 6'd5, 1);
        drive_heads();
        wait_drain("t2_rr_drain", 20);
        repeat (6) tick();
        push_cmd(2, C_ACT, 6'd6, -1);
        push_cmd(5, C_ACT, 6'd7, 1);
        drive_heads();
        wait_drain("t2_wrap_drain", 20);

        // Two CAS commands spaced by tCCD.
        do_reset();
        tick();
        push_cmd(1, C_RD, 6'd8, -1);
        push_cmd(2, C_WR, 6'd9, 2);
        drive_heads();
        wait_drain("t3_drain", 20);

        // Downstream stall for five cycles.
        do_reset();
        i_cmd_ready = 1'b0;
        tick();
        push_cmd(4, C_ACT, 6'd10, -1);
        push_cmd(6, C_ACT, 6'd11, 6);
        drive_heads();
        @(negedge i_clk);
        check("t4_first_dequeue", 64'(o_dequeue), 64'h0010);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge i_clk);
            check("t4_stall_dequeue", 64'(o_dequeue), 64'd0);
            check("t4_hold_out", 64'({o_cmd_valid, o_grant_idx, o_column}), 64'({1'b1, 4'd4, 6'd10}));
        end
        tick();
        i_cmd_ready = 1'b1;
        @(negedge i_clk);
        check("t4_resume_dequeue", 64'(o_dequeue), 64'h0040);
        wait_drain("t4_drain", 20);

        // PRE then ACT on the same bank, tRP apart.
        do_reset();
        tick();
        push_cmd(7, C_PRE, 6'd12, -1);
        push_cmd(7, C_ACT, 6'd13, 4);
        drive_heads();
        wait_drain("t5_drain", 20);

        // Asynchronous reset with a held command and live timers.
        do_reset();
        i_cmd_ready = 1'b0;
        tick();
        push_cmd(9, C_ACT, 6'd14, -1);
        drive_heads();
        @(negedge i_clk);
        check("t6_first_dequeue", 64'(o_dequeue), 64'h0200);
        tick();
        tick();
        i_rst = 1'b1;
        #1;
        check("t6_async_valid", 64'(o_cmd_valid), 64'd0);
        check("t6_async_dequeue", 64'(o_dequeue), 64'd0);
        check("t6_async_fields", 64'({o_cmd, o_grant_idx, o_column}), 64'd0);
        i_cmd_ready = 1'b1;
        flush_bench();
        tick();
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
`ifdef ISSUE_STATS_EN
        check("t6_stats_cleared", 64'({o_issue_count, o_stall_count}), 64'd0);
`endif
        tick();
        push_cmd(9, C_ACT, 6'd15, -1);
        push_cmd(9, C_RD,  6'd16, 4);
        drive_heads();
        @(negedge i_clk);
        check("t6_post_dequeue", 64'(o_dequeue), 64'h0200);
        wait_drain("t6_drain", 20);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
